// File: rtl/dmover_multich_rd.sv
// Multichannel DataMover read engine: walks the tile/row address pattern of
// a feature map, issues one MM2S command per row and forwards the returned
// stream to the compute array with backpressure and a frame-level tlast.
module dmover_multich_rd #(
    parameter int DATA_W = 128,
    parameter int CMD_W  = 72
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       s_axis_dmrconfig_tdata,
    input  logic              s_axis_dmrconfig_tvalid,
    output logic              s_axis_dmrconfig_tready,
    output logic [CMD_W-1:0]  m_axis_mm2s_cmd_tdata,
    output logic              m_axis_mm2s_cmd_tvalid,
    input  logic              m_axis_mm2s_cmd_tready,
    input  logic [7:0]        s_axis_mm2s_sts_tdata,
    input  logic              s_axis_mm2s_sts_tvalid,
    output logic              s_axis_mm2s_sts_tready,
    input  logic [DATA_W-1:0] s_axis_mm2s_tdata,
    input  logic              s_axis_mm2s_tvalid,
    output logic              s_axis_mm2s_tready,
    output logic [DATA_W-1:0] m_axis_dmr_tdata,
    output logic              m_axis_dmr_tvalid,
    input  logic              m_axis_dmr_tready,
    output logic              m_axis_dmr_tlast,
    output logic              done,
    output logic              err,
    output logic [2:0]        status_dmr
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CONFIG      = 3'd1,
        PARA_CAL    = 3'd2,
        CMD         = 3'd3,
        RD          = 3'd4,
        ADDR_UPDATE = 3'd5,
        DONE        = 3'd6
    } state_t;

    state_t             state_r, next_s;
    logic [1:0]         cfg_idx_r;
    logic [15:0]        chin_r;
    logic [11:0]        img_w_r, img_h_r;
    logic [7:0]         r_tile_r;
    logic [15:0]        len_unit_r;
    logic [22:0]        addr_unit_r;
    logic [31:0]        row_shift_r;
    logic [31:0]        rd_addr_r, tile_base_r;
    logic [11:0]        row_r;
    logic [7:0]         tile_r;
    logic [15:0]        cnt_unit_r;
    logic               cmd_valid_r, cfg_ready_r, sts_ready_r, err_r, done_r;
    logic [CMD_W-1:0]   cmd_data_r;

    logic               cfg_hs_s, word2_hs_s, cmd_hs_s, rd_en_s, rd_hs_s, sts_hs_s, sts_bad_s;
    logic               last_beat_s, last_row_s, last_tile_s, degenerate_s;
    logic [15:0]        len_unit_s;
    logic [22:0]        addr_unit_s;
    logic [31:0]        row_shift_s;
    logic [3:0]         sts_tag_unused_s;

    assign cfg_hs_s     = s_axis_dmrconfig_tvalid & cfg_ready_r;
    assign word2_hs_s   = cfg_hs_s & (cfg_idx_r == 2'd2);
    assign cmd_hs_s     = cmd_valid_r & m_axis_mm2s_cmd_tready;
    assign rd_en_s      = (state_r == RD);
    assign rd_hs_s      = rd_en_s & s_axis_mm2s_tvalid & m_axis_dmr_tready;
    assign sts_hs_s     = s_axis_mm2s_sts_tvalid & sts_ready_r;
    assign sts_bad_s    = ~s_axis_mm2s_sts_tdata[7] | (s_axis_mm2s_sts_tdata[6:4] != 3'd0);
    assign sts_tag_unused_s = s_axis_mm2s_sts_tdata[3:0];

    // Row/tile geometry, truncated to the widths of the holding registers
    assign len_unit_s   = {4'd0, img_w_r} * (chin_r >> 3);
    assign addr_unit_s  = {11'd0, img_w_r} * {6'd0, chin_r, 1'b0};
    assign row_shift_s  = {9'd0, addr_unit_s} * {24'd0, r_tile_r};

    assign last_beat_s  = (cnt_unit_r == (len_unit_r - 16'd1));
    assign last_row_s   = (({1'b0, row_r} + 13'd1) >= {1'b0, img_h_r});
    assign last_tile_s  = (({1'b0, tile_r} + 9'd1) >= {1'b0, r_tile_r});
    assign degenerate_s = (len_unit_r == 16'd0) | (img_h_r == 12'd0) | (r_tile_r == 8'd0);

    // Read data passes straight through while a row is being drained
    assign m_axis_dmr_tdata        = s_axis_mm2s_tdata;
    assign m_axis_dmr_tvalid       = rd_en_s & s_axis_mm2s_tvalid;
    assign s_axis_mm2s_tready      = rd_en_s & m_axis_dmr_tready;
    assign m_axis_dmr_tlast        = rd_en_s & s_axis_mm2s_tvalid & last_beat_s & last_row_s & last_tile_s;

    assign s_axis_dmrconfig_tready = cfg_ready_r;
    assign m_axis_mm2s_cmd_tdata   = cmd_data_r;
    assign m_axis_mm2s_cmd_tvalid  = cmd_valid_r;
    assign s_axis_mm2s_sts_tready  = sts_ready_r;
    assign done                    = done_r;
    assign err                     = err_r;
    assign status_dmr              = state_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= next_s;
    end

    // Next-state decode
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:        if (cfg_hs_s) next_s = CONFIG; else next_s = IDLE;
            CONFIG:      if (word2_hs_s) next_s = PARA_CAL; else next_s = CONFIG;
            PARA_CAL:    if (degenerate_s) next_s = DONE; else next_s = CMD;
            CMD:         if (cmd_hs_s) next_s = RD; else next_s = CMD;
            RD:          if (rd_hs_s && last_beat_s) next_s = ADDR_UPDATE; else next_s = RD;
            ADDR_UPDATE: if (last_row_s && last_tile_s) next_s = DONE; else next_s = CMD;
            DONE:        next_s = IDLE;
            default:     next_s = IDLE;
        endcase
    end

    // Capture the three config words and register the derived geometry
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_idx_r   <= 2'd0;
            chin_r      <= 16'd0;
            img_w_r     <= 12'd0;
            img_h_r     <= 12'd0;
            r_tile_r    <= 8'd0;
            len_unit_r  <= 16'd0;
            addr_unit_r <= 23'd0;
            row_shift_r <= 32'd0;
        end else if (cfg_hs_s) begin
            case (cfg_idx_r)
                2'd0: begin
                    chin_r    <= s_axis_dmrconfig_tdata[15:0];
                    cfg_idx_r <= 2'd1;
                end
                2'd1: begin
                    img_w_r   <= s_axis_dmrconfig_tdata[11:0];
                    img_h_r   <= s_axis_dmrconfig_tdata[23:12];
                    r_tile_r  <= s_axis_dmrconfig_tdata[31:24];
                    cfg_idx_r <= 2'd2;
                end
                2'd2: begin
                    len_unit_r  <= len_unit_s;
                    addr_unit_r <= addr_unit_s;
                    row_shift_r <= row_shift_s;
                    cfg_idx_r   <= 2'd0;
                end
                default: cfg_idx_r <= 2'd0;
            endcase
        end
    end

    // Address walk: rows inner, tiles outer; beat counter within a row
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_r   <= 32'd0;
            tile_base_r <= 32'd0;
            row_r       <= 12'd0;
            tile_r      <= 8'd0;
            cnt_unit_r  <= 16'd0;
        end else if (word2_hs_s) begin
            rd_addr_r   <= s_axis_dmrconfig_tdata;
            tile_base_r <= s_axis_dmrconfig_tdata;
            row_r       <= 12'd0;
            tile_r      <= 8'd0;
            cnt_unit_r  <= 16'd0;
        end else if (rd_hs_s) begin
            cnt_unit_r  <= last_beat_s ? 16'd0 : cnt_unit_r + 16'd1;
        end else if (state_r == ADDR_UPDATE) begin
            if (!last_row_s) begin
                row_r     <= row_r + 12'd1;
                rd_addr_r <= rd_addr_r + row_shift_r;
            end else begin
                row_r <= 12'd0;
                if (!last_tile_s) begin
                    tile_r      <= tile_r + 8'd1;
                    tile_base_r <= tile_base_r + {9'd0, addr_unit_r};
                    rd_addr_r   <= tile_base_r + {9'd0, addr_unit_r};
                end
            end
        end else if (state_r == DONE) begin
            row_r      <= 12'd0;
            tile_r     <= 8'd0;
            cnt_unit_r <= 16'd0;
        end
    end

    // MM2S command: load on entry to CMD, hold until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_r <= 1'b0;
            cmd_data_r  <= '0;
        end else if ((state_r == CMD) && !cmd_valid_r) begin
            cmd_valid_r <= 1'b1;
            cmd_data_r  <= {4'd0, 4'd0, rd_addr_r, 1'b0, 1'b1, 6'd0, 1'b1, addr_unit_r};
        end else if (cmd_hs_s) begin
            cmd_valid_r <= 1'b0;
        end
    end

    // Handshake readies, completion pulse and sticky status error
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready_r <= 1'b0;
            sts_ready_r <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            cfg_ready_r <= (next_s == IDLE) || (next_s == CONFIG);
            sts_ready_r <= 1'b1;
            done_r      <= (next_s == DONE);
            if (sts_hs_s && sts_bad_s)
                err_r <= 1'b1;
            else if (cfg_hs_s && (cfg_idx_r == 2'd0))
                err_r <= 1'b0;
        end
    end

endmodule

// File: doc/dmover_multich_rd.md
Name: dmover_multich_rd

Overview:
Read-side companion to the multichannel DataMover writer. It takes a 3-word config, walks the same tile/row address pattern the writer uses, and issues one AXI DataMover MM2S command per row. It forwards the returned 128-bit stream to the compute array with backpressure, generates tlast on the final beat of the feature map, and monitors MM2S status for errors.

Parameters:
DATA_W, 128, stream data width (fixed; 8 channels x 16 bit per beat)
CMD_W, 72, DataMover command width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_axis_dmrconfig_tdata  in  32  config word
s_axis_dmrconfig_tvalid  in  1  config valid
s_axis_dmrconfig_tready  out  1  config ready
m_axis_mm2s_cmd_tdata  out  72  {rsvd4=0, tag4=0, addr32, drr=0, eof=1, dsa6=0, type=1, btt23}
m_axis_mm2s_cmd_tvalid  out  1  command valid
m_axis_mm2s_cmd_tready  in  1  command ready
s_axis_mm2s_sts_tdata  in  8  DataMover status
s_axis_mm2s_sts_tvalid  in  1  status valid
s_axis_mm2s_sts_tready  out  1  status ready (constant 1 outside reset)
s_axis_mm2s_tdata  in  128  DDR read data
s_axis_mm2s_tvalid  in  1  read data valid
s_axis_mm2s_tready  out  1  read data ready
m_axis_dmr_tdata  out  128  data to compute array
m_axis_dmr_tvalid  out  1  output valid
m_axis_dmr_tready  in  1  output ready
m_axis_dmr_tlast  out  1  last beat of whole transfer
done  out  1  1-cycle pulse when transfer completes
err  out  1  sticky status error, cleared on config word 0
status_dmr  out  3  current state (debug)

Behaviour:
- Reset values: all outputs 0 except s_axis_mm2s_sts_tready, which is 0 during reset and 1 afterwards. State enters IDLE.
- Config handshake: accept a word when tvalid & tready. tready is high in IDLE/CONFIG until word 2 is accepted, then deasserts next cycle.
  - Word 0 [15:0]: chin_perrtile. Word 0 acceptance also clears err.
  - Word 1: img_w[11:0], img_h[23:12], r_tile[31:24].
  - Word 2: base address.
- Derived values, registered the cycle after word 2 is accepted:
  - len_unit[15:0] = img_w*(chin>>3) beats per row.
  - addr_unit[22:0] = img_w*(chin<<1) bytes.
  - row_shift[31:0] = addr_unit*r_tile, truncated to 32 bits.
- States: IDLE -> CONFIG -> PARA_CAL -> CMD -> RD -> ADDR_UPDATE -> (CMD | DONE) -> IDLE.
  - PARA_CAL: if len_unit==0, img_h==0 or r_tile==0, go to DONE with no command issued.
  - CMD: cmd_tdata is loaded with addr=rd_addr and btt=addr_unit; tvalid is held until cmd_tready. After the handshake, tvalid drops the next cycle and the state moves to RD.
  - RD: combinational passthrough.
    - m_axis_dmr_tdata = s_axis_mm2s_tdata.
    - m_axis_dmr_tvalid = rd_en & s_axis_mm2s_tvalid.
    - s_axis_mm2s_tready = rd_en & m_axis_dmr_tready.
    - cnt_unit increments on each transfer. On the transfer where cnt_unit==len_unit-1, go to ADDR_UPDATE; rd_en is low from the next cycle.
  - m_axis_dmr_tlast is combinational: high during the final beat of the last row of the last tile.
  - ADDR_UPDATE, loop order rows inner, tiles outer:
    - If row+1 < img_h: rd_addr += row_shift.
    - Otherwise row=0; if tile+1 < r_tile, tile_base += addr_unit and rd_addr = tile_base + addr_unit; otherwise go to DONE.
  - DONE: done=1 for one cycle; counters cleared; return to IDLE.
- Only one command is outstanding at a time; the next command is not issued before the current row's data has fully drained.
- Status monitoring: on sts_tvalid, if sts[7]==0 or sts[6:4]!=0, err is set and stays set. The data path is not aborted.
- Output stall (m_axis_dmr_tready low) stalls the input; no beat is dropped or duplicated.
- Config words arriving outside IDLE/CONFIG are not accepted (tready low).
- Reset mid-operation: the state returns to IDLE and cmd_tvalid, dmr_tvalid and tready drop in the same cycle. The DataMover is not flushed; this is a system-level concern.

Test Plan:
- Basic transfer. Stimulus: config chin=16, img_w=4, img_h=3, r_tile=2, base=0x8000_0000. Required response:
  - 6 commands with addresses 0x80000000, 0x80000100, 0x80000200, 0x80000080, 0x80000180, 0x80000280.
  - First command tdata = 72'h00_80000000_40800080.
  - 48 beats total, tlast only on beat 48, done pulses once.
- Backpressure. Stimulus: same config, with random m_axis_dmr_tready and s_axis_mm2s_tvalid at 50%. Required response: output beat sequence identical to input, with no loss or duplication.
- Command stall. Stimulus: cmd_tready held low 20 cycles. Required response: cmd_tvalid and tdata stay stable, and no data ready is asserted before the handshake.
- Status error. Stimulus: status 0x00 returned after row 2. Required response: err=1 and remains set through DONE; the next config word 0 clears it.
- Degenerate config. Stimulus: img_h=0. Required response: no command issued, done pulse about 3 cycles after word 2.
- Mid-transfer reset. Stimulus: rst=1 at beat 10. Required response: all valids low the next cycle; a new config then runs the basic transfer cleanly.
